wb_req_sender: RTL and testbench

//  EXU-side initiator of the writeback request channel consumed by the register file.

---
 rtl/wb_req_sender_pkg.sv | 21 ++
 rtl/wb_req_sender_load_align.sv | 34 +++
 rtl/wb_req_sender.sv | 119 +++++++++++
 tb/tb_wb_req_sender.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_req_sender_pkg.sv
// Shared definitions for the writeback request sender.
//   state_t    : FSM encoding (2'd3 is unused and recovers to IDLE)
//   FMT_*      : funct3 codes of the load instructions
//   NUM_RESET  : value of the sequence counter and num payload after reset
package wb_req_sender_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_LSU = 2'd1,
        SEND     = 2'd2
    } state_t;

    localparam logic [2:0] FMT_LB  = 3'b000;
    localparam logic [2:0] FMT_LH  = 3'b001;
    localparam logic [2:0] FMT_LW  = 3'b010;
    localparam logic [2:0] FMT_LBU = 3'b100;
    localparam logic [2:0] FMT_LHU = 3'b101;

    localparam logic [63:0] NUM_RESET = 64'd0;

endpackage

// File: rtl/wb_req_sender_load_align.sv
// Combinational load data alignment and extension.
//   rdata : raw aligned word returned by the LSU
//   off   : byte offset of the access (mem_addr[1:0])
//   fmt   : funct3 of the load
//   wdata : value written to the destination register
// The word is shifted right by the byte offset with zero fill, so a halfword
// at offset 3 sees a zero upper byte. Unknown formats pass the raw word.
module wb_req_sender_load_align
    import wb_req_sender_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            off,
    input  logic [2:0]            fmt,
    output logic [DATA_WIDTH-1:0] wdata
);

    logic [DATA_WIDTH-1:0] sh;

    always_comb begin
        sh    = rdata >> {off, 3'b000};
        wdata = rdata;
        case (fmt)
            FMT_LB:  wdata = {{(DATA_WIDTH-8){sh[7]}}, sh[7:0]};
            FMT_LH:  wdata = {{(DATA_WIDTH-16){sh[15]}}, sh[15:0]};
            FMT_LW:  wdata = sh;
            FMT_LBU: wdata = {{(DATA_WIDTH-8){1'b0}}, sh[7:0]};
            FMT_LHU: wdata = {{(DATA_WIDTH-16){1'b0}}, sh[15:0]};
            default: wdata = rdata;
        endcase
    end

endmodule

// File: rtl/wb_req_sender.sv
// EXU-side initiator of the writeback request channel to the register file.
// Accepts one retired instruction at a time; loads wait for the LSU read data,
// which is aligned/extended before the request is presented.
//   clock, reset          : clock, synchronous active-low reset
//   in_*                  : retired instruction from EXU (in_valid/in_ready)
//   lsu_rvalid/rready/rdata : LSU read response
//   rd_valid/rd_ready     : write request to the register file
//   waddr/wdata/wen/next_pc/num/sim_lsu_addr : request payload
//   busy                  : FSM not idle
//   dbg_state             : raw FSM state
//
// Handshakes: a transfer happens on a rising edge where both valid and ready
// are high. rd_valid, once raised, stays high with a constant payload until
// rd_ready is seen; in_ready and lsu_rready never depend on the valid input.
module wb_req_sender
    import wb_req_sender_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_waddr,
    input  logic                  in_wen,
    input  logic [DATA_WIDTH-1:0] in_alu_result,
    input  logic [31:0]           in_next_pc,
    input  logic                  in_is_load,
    input  logic [2:0]            in_load_fmt,
    input  logic [31:0]           in_mem_addr,
    input  logic                  lsu_rvalid,
    output logic                  lsu_rready,
    input  logic [DATA_WIDTH-1:0] lsu_rdata,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  wen,
    output logic [31:0]           next_pc,
    output logic [63:0]           num,
    output logic [31:0]           sim_lsu_addr,
    output logic                  busy,
    output logic [1:0]            dbg_state
);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  wen_q;
    logic [31:0]           next_pc_q;
    logic [31:0]           mem_addr_q;
    logic [2:0]            fmt_q;
    logic [63:0]           num_q;
    logic [63:0]           cnt_q;
    logic [DATA_WIDTH-1:0] load_data;

    wb_req_sender_load_align #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_load_align (
        .rdata (lsu_rdata),
        .off   (mem_addr_q[1:0]),
        .fmt   (fmt_q),
        .wdata (load_data)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (in_valid)   state_d = in_is_load ? WAIT_LSU : SEND;
            WAIT_LSU: if (lsu_rvalid) state_d = SEND;
            SEND:     if (rd_ready)   state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= IDLE;
            waddr_q    <= '0;
            wdata_q    <= '0;
            wen_q      <= 1'b0;
            next_pc_q  <= '0;
            mem_addr_q <= '0;
            fmt_q      <= '0;
            num_q      <= NUM_RESET;
            cnt_q      <= NUM_RESET;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && in_valid) begin
                waddr_q    <= in_waddr;
                wen_q      <= in_wen;
                next_pc_q  <= in_next_pc;
                mem_addr_q <= in_mem_addr;
                fmt_q      <= in_load_fmt;
                num_q      <= cnt_q + 64'd1;
                cnt_q      <= cnt_q + 64'd1;
                // Loads fill wdata later from the LSU response.
                if (!in_is_load) wdata_q <= in_alu_result;
            end
            if (state_q == WAIT_LSU && lsu_rvalid) begin
                wdata_q <= load_data;
            end
        end
    end

    assign in_ready     = (state_q == IDLE);
    assign lsu_rready   = (state_q == WAIT_LSU);
    assign rd_valid     = (state_q == SEND);
    assign busy         = (state_q != IDLE);
    assign dbg_state    = state_q;
    assign waddr        = waddr_q;
    assign wdata        = wdata_q;
    assign wen          = wen_q;
    assign next_pc      = next_pc_q;
    assign num          = num_q;
    assign sim_lsu_addr = mem_addr_q;

endmodule

// File: tb/tb_wb_req_sender.sv
module tb_wb_req_sender;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_waddr;
    logic        in_wen;
    logic [31:0] in_alu_result;
    logic [31:0] in_next_pc;
    logic        in_is_load;
    logic [2:0]  in_load_fmt;
    logic [31:0] in_mem_addr;
    logic        lsu_rvalid;
    logic        lsu_rready;
    logic [31:0] lsu_rdata;
    logic        rd_valid;
    logic        rd_ready;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        wen;
    logic [31:0] next_pc;
    logic [63:0] num;
    logic [31:0] sim_lsu_addr;
    logic        busy;
    logic [1:0]  dbg_state;

    int vec_cnt = 0;
    int err_cnt = 0;

    // expected write: {waddr[5], wen[1], wdata[32], next_pc[32], num[64]}
    logic [133:0] exp_q[$];
    logic [133:0] mon_e;
    logic [63:0]  exp_num;

    wb_req_sender dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_waddr      (in_waddr),
        .in_wen        (in_wen),
        .in_alu_result (in_alu_result),
        .in_next_pc    (in_next_pc),
        .in_is_load    (in_is_load),
        .in_load_fmt   (in_load_fmt),
        .in_mem_addr   (in_mem_addr),
        .lsu_rvalid    (lsu_rvalid),
        .lsu_rready    (lsu_rready),
        .lsu_rdata     (lsu_rdata),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .waddr         (waddr),
        .wdata         (wdata),
        .wen           (wen),
        .next_pc       (next_pc),
        .num           (num),
        .sim_lsu_addr  (sim_lsu_addr),
        .busy          (busy),
        .dbg_state     (dbg_state)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // scoreboard: every accepted write request is popped from exp_q
    always @(negedge clock) begin
        #3;
        if (reset && rd_valid && rd_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_waddr", {59'd0, waddr}, {59'd0, mon_e[133:129]});
                check("wr_wen", {63'd0, wen}, {63'd0, mon_e[128]});
                check("wr_wdata", {32'd0, wdata}, {32'd0, mon_e[127:96]});
                check("wr_next_pc", {32'd0, next_pc}, {32'd0, mon_e[95:64]});
                check("wr_num", num, mon_e[63:0]);
            end
        end
    end

    // driver: present one instruction in IDLE for exactly one cycle
    task automatic issue(input logic [4:0] a, input logic w, input logic [31:0] alu,
                         input logic [31:0] npc, input logic ld, input logic [2:0] f,
                         input logic [31:0] ma, input logic [31:0] exp_wd, input logic push);
        check("in_ready_idle", {63'd0, in_ready}, 64'd1);
        exp_num = exp_num + 64'd1;
        if (push) exp_q.push_back({a, w, exp_wd, npc, exp_num});
        in_valid      = 1'b1;
        in_waddr      = a;
        in_wen        = w;
        in_alu_result = alu;
        in_next_pc    = npc;
        in_is_load    = ld;
        in_load_fmt   = f;
        in_mem_addr   = ma;
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    // load with a 4-cycle LSU delay, rd_ready held high
    task automatic run_load(input string tag, input logic [2:0] f, input logic [31:0] ma,
                            input logic [31:0] d, input logic [31:0] exp_wd);
        issue(5'd7, 1'b1, 32'hDEAD_BEEF, 32'h3000_0100, 1'b1, f, ma, exp_wd, 1'b1);
        check("wait_lsu_rready", {63'd0, lsu_rready}, 64'd1);
        check("wait_lsu_no_rd", {63'd0, rd_valid}, 64'd0);
        repeat (4) @(negedge clock);
        lsu_rvalid = 1'b1;
        lsu_rdata  = d;
        @(negedge clock);
        lsu_rvalid = 1'b0;
        check("load_latency", {63'd0, rd_valid}, 64'd1);
        check(tag, {32'd0, wdata}, {32'd0, exp_wd});
        check("load_addr", {32'd0, sim_lsu_addr}, {32'd0, ma});
        @(negedge clock);
    endtask

    initial begin
        reset         = 1'b0;
        in_valid      = 1'b0;
        in_waddr      = '0;
        in_wen        = 1'b0;
        in_alu_result = '0;
        in_next_pc    = '0;
        in_is_load    = 1'b0;
        in_load_fmt   = '0;
        in_mem_addr   = '0;
        lsu_rvalid    = 1'b0;
        lsu_rdata     = '0;
        rd_ready      = 1'b0;
        exp_num       = 64'd0;

        // 1. reset
        repeat (3) @(negedge clock);
        reset = 1'b1;
        check("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_num", num, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_wdata", {32'd0, wdata}, 64'd0);
        check("rst_state", {62'd0, dbg_state}, 64'd0);
        @(negedge clock);

        // 2. ALU op, rd_valid one cycle after accept
        rd_ready = 1'b1;
        issue(5'd5, 1'b1, 32'h1234_5678, 32'h3000_0004, 1'b0, 3'd0, 32'd0, 32'h1234_5678, 1'b1);
        check("alu_rd_valid", {63'd0, rd_valid}, 64'd1);
        check("alu_wdata", {32'd0, wdata}, 64'h1234_5678);
        check("alu_num", num, 64'd1);
        check("alu_busy", {63'd0, busy}, 64'd1);
        check("alu_in_ready_send", {63'd0, in_ready}, 64'd0);
        @(negedge clock);
        check("alu_rd_drop", {63'd0, rd_valid}, 64'd0);
        check("alu_in_ready_back", {63'd0, in_ready}, 64'd1);

        // 3. load alignment
        run_load("lb_off3", 3'b000, 32'h8000_0003, 32'h80FF_7F01, 32'hFFFF_FF80);
        run_load("lbu_off3", 3'b100, 32'h8000_0003, 32'h80FF_7F01, 32'h0000_0080);
        run_load("lh_off2", 3'b001, 32'h8000_0002, 32'h80FF_7F01, 32'hFFFF_80FF);
        run_load("lh_off3", 3'b001, 32'h8000_0003, 32'h80FF_7F01, 32'h0000_0080);
        run_load("lw_off0", 3'b010, 32'h8000_0000, 32'h80FF_7F01, 32'h80FF_7F01);
        run_load("lhu_off0", 3'b101, 32'h8000_0000, 32'h80FF_7F01, 32'h0000_7F01);
        run_load("lhu_off1", 3'b101, 32'h8000_0001, 32'h80FF_7F01, 32'h0000_FF7F);
        run_load("fmt_raw", 3'b011, 32'h8000_0002, 32'h80FF_7F01, 32'h80FF_7F01);

        // 4. backpressure in SEND, x0 write passed through
        rd_ready = 1'b0;
        issue(5'd0, 1'b1, 32'hA5A5_A5A5, 32'h0000_1000, 1'b0, 3'd0, 32'd0, 32'hA5A5_A5A5, 1'b1);
        for (int i = 0; i < 5; i++) begin
            in_valid      = ~in_valid;
            in_alu_result = $urandom;
            in_waddr      = 5'($urandom_range(1, 31));
            lsu_rvalid    = ~lsu_rvalid;
            lsu_rdata     = $urandom;
            check("hold_rd_valid", {63'd0, rd_valid}, 64'd1);
            check("hold_in_ready", {63'd0, in_ready}, 64'd0);
            check("hold_wdata", {32'd0, wdata}, 64'hA5A5_A5A5);
            check("hold_waddr", {59'd0, waddr}, 64'd0);
            check("hold_num", num, exp_num);
            @(negedge clock);
        end
        in_valid   = 1'b0;
        lsu_rvalid = 1'b0;
        rd_ready   = 1'b1;
        check("hold_still_valid", {63'd0, rd_valid}, 64'd1);
        @(negedge clock);
        check("hold_release", {63'd0, rd_valid}, 64'd0);
        issue(5'd3, 1'b0, 32'h0000_00AA, 32'h0000_1004, 1'b0, 3'd0, 32'd0, 32'h0000_00AA, 1'b1);
        check("no_extra_capture", num, exp_num);
        @(negedge clock);

        // 5. reset while waiting for the LSU
        issue(5'd9, 1'b1, 32'd0, 32'h0000_2000, 1'b1, 3'b010, 32'h8000_0010, 32'd0, 1'b0);
        check("mid_rst_wait", {63'd0, lsu_rready}, 64'd1);
        reset = 1'b0;
        @(negedge clock);
        reset   = 1'b1;
        exp_num = 64'd0;
        check("mid_rst_busy", {63'd0, busy}, 64'd0);
        check("mid_rst_state", {62'd0, dbg_state}, 64'd0);
        check("mid_rst_num", num, 64'd0);
        lsu_rvalid = 1'b1;
        lsu_rdata  = 32'h1111_2222;
        @(negedge clock);
        lsu_rvalid = 1'b0;
        check("late_lsu_rd_valid", {63'd0, rd_valid}, 64'd0);
        check("late_lsu_busy", {63'd0, busy}, 64'd0);
        @(negedge clock);

        // 6. consecutive instructions and counter wrap
        for (int i = 0; i < 3; i++) begin
            issue(5'(i + 1), 1'b1, 32'h100 + 32'(i), 32'h4000_0000 + 32'(4 * i), 1'b0, 3'd0,
                  32'd0, 32'h100 + 32'(i), 1'b1);
            check("seq_num", num, 64'(i + 1));
            @(negedge clock);
        end
        force dut.cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clock);
        release dut.cnt_q;
        exp_num = 64'hFFFF_FFFF_FFFF_FFFF;
        issue(5'd12, 1'b1, 32'hCAFE_0000, 32'h5000_0000, 1'b0, 3'd0, 32'd0, 32'hCAFE_0000, 1'b1);
        check("wrap_num", num, 64'd0);
        @(negedge clock);
        issue(5'd13, 1'b1, 32'hCAFE_0001, 32'h5000_0004, 1'b0, 3'd0, 32'd0, 32'hCAFE_0001, 1'b1);
        check("post_wrap_num", num, 64'd1);
        @(negedge clock);
        @(negedge clock);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
